// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central stall/flush controller for the 5-stage pipeline. Merges D-cache
// miss stalls, load-use hazards and taken-branch flushes into one prioritized
// set of PC / IF/ID / ID/EX controls. A small FSM sequences each D-cache miss
// (RUN -> MISS -> RELEASE -> RUN) with a miss timeout into a sticky ERR state.
//
// Build option: define HAZ_PERF_CNT_EN to build the saturating performance
// counters. When undefined, the counter ports remain and are tied to zero.

module pipeline_hazard_ctrl #(
   parameter int unsigned ACK_TIMEOUT = 1023,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [4:0]       ifid_rs_i,
   input  logic [4:0]       ifid_rt_i,
   input  logic             idex_memread_i,
   input  logic [4:0]       idex_rt_i,
   input  logic             branch_taken_i,
   input  logic             dmem_req_i,
   input  logic             dmem_hit_i,
   input  logic             dmem_ack_i,
   output logic             pc_write_o,
   output logic             ifid_write_o,
   output logic             ifid_flush_o,
   output logic             idex_bubble_o,
   output logic             memstall_o,
   output logic             err_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] luse_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   // Miss counter only needs to reach ACK_TIMEOUT-1 before the timeout fires.
   localparam int unsigned MC_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [MC_W-1:0] MISS_LAST = MC_W'(ACK_TIMEOUT - 1);

   localparam logic [1:0] ST_RUN     = 2'd0;
   localparam logic [1:0] ST_MISS    = 2'd1;
   localparam logic [1:0] ST_RELEASE = 2'd2;
   localparam logic [1:0] ST_ERR     = 2'd3;

   logic [1:0]      state_q;
   logic [1:0]      state_d;
   logic [MC_W-1:0] miss_cnt_q;
   logic            err_q;
   logic            luse_c;
   logic            memstall_c;

   // Miss sequencing state register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; an ack coinciding with the timeout cycle still releases.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (dmem_req_i && !dmem_hit_i) begin
               state_d = ST_MISS;
            end
         end
         ST_MISS: begin
            if (dmem_ack_i) begin
               state_d = ST_RELEASE;
            end else if (miss_cnt_q == MISS_LAST) begin
               state_d = ST_ERR;
            end
         end
         ST_RELEASE: state_d = ST_RUN;
         ST_ERR:     state_d = ST_ERR;
         default:    state_d = ST_RUN;
      endcase
   end

   // Cycles spent waiting in MISS; cleared whenever the FSM is elsewhere.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         miss_cnt_q <= '0;
      end else if (state_q == ST_MISS && state_d == ST_MISS) begin
         miss_cnt_q <= miss_cnt_q + MC_W'(1);
      end else begin
         miss_cnt_q <= '0;
      end
   end

   // Sticky timeout flag, cleared only by reset.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         err_q <= 1'b0;
      end else if (state_d == ST_ERR) begin
         err_q <= 1'b1;
      end
   end

   assign err_o = err_q;

   // Hazard detection; RELEASE ignores the stale hit/miss of the retiring access.
   always_comb begin
      luse_c = idex_memread_i && (idex_rt_i != 5'd0) &&
               ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));
      memstall_c = (state_q == ST_MISS) || (state_q == ST_ERR) ||
                   ((state_q == ST_RUN) && dmem_req_i && !dmem_hit_i);
   end

   // Prioritized pipeline controls: reset, memstall, load-use, branch, normal.
   always_comb begin
      pc_write_o    = 1'b1;
      ifid_write_o  = 1'b1;
      ifid_flush_o  = 1'b0;
      idex_bubble_o = 1'b0;
      memstall_o    = 1'b0;
      if (!rst_i) begin
         pc_write_o    = 1'b0;
         ifid_write_o  = 1'b0;
         ifid_flush_o  = 1'b1;
         idex_bubble_o = 1'b1;
      end else if (memstall_c) begin
         pc_write_o    = 1'b0;
         ifid_write_o  = 1'b0;
         memstall_o    = 1'b1;
      end else if (luse_c) begin
         pc_write_o    = 1'b0;
         ifid_write_o  = 1'b0;
         idex_bubble_o = 1'b1;
      end else if (branch_taken_i) begin
         ifid_flush_o  = 1'b1;
      end
   end

`ifdef HAZ_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] luse_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;

   // Saturating event counters driven by the final prioritized controls.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stall_cnt_q <= '0;
         luse_cnt_q  <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (memstall_o && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end
         if (idex_bubble_o && (luse_cnt_q != '1)) begin
            luse_cnt_q <= luse_cnt_q + CNT_W'(1);
         end
         if (ifid_flush_o && (flush_cnt_q != '1)) begin
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
         end
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign luse_cnt_o  = luse_cnt_q;
   assign flush_cnt_o = flush_cnt_q;
`else
   assign stall_cnt_o = '0;
   assign luse_cnt_o  = '0;
   assign flush_cnt_o = '0;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the 5-stage pipeline. Combines data-cache miss stalls, load-use hazards and taken-branch flushes into one prioritized set of write-enable, flush and bubble controls for the PC, IF/ID and ID/EX registers. Its memstall output drives the memstall input of every pipeline register. A small FSM sequences each D-cache miss, including a one-cycle release and a miss timeout.

## Interface
- ACK_TIMEOUT, 1023: maximum cycles in MISS without dmem_ack_i before the error state.
- CNT_W, 16: width of the performance counters.

- clk_i  in  1  clock; all state on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- ifid_rs_i  in  5  rs field of the instruction in IF/ID.
- ifid_rt_i  in  5  rt field of the instruction in IF/ID.
- idex_memread_i  in  1  instruction in ID/EX is a load.
- idex_rt_i  in  5  destination rt of the instruction in ID/EX.
- branch_taken_i  in  1  branch resolved taken in ID this cycle.
- dmem_req_i  in  1  MEM stage issues a D-cache read or write.
- dmem_hit_i  in  1  D-cache hit; valid when dmem_req_i=1.
- dmem_ack_i  in  1  refill/writeback complete; one-cycle pulse.
- pc_write_o  out  1  PC update enable.
- ifid_write_o  out  1  IF/ID load enable.
- ifid_flush_o  out  1  zero IF/ID on the next edge.
- idex_bubble_o  out  1  zero the ID/EX control fields (wb, mem, ex).
- memstall_o  out  1  freeze all pipeline registers.
- err_o  out  1  sticky miss-timeout flag.
- stall_cnt_o  out  CNT_W  memstall cycles.
- luse_cnt_o  out  CNT_W  load-use bubbles.
- flush_cnt_o  out  CNT_W  branch flushes.

## Operation
- FSM states: RUN, MISS, RELEASE, ERR. Reset state is RUN.
- RUN:
  - dmem_req_i=1 and dmem_hit_i=0 -> MISS.
  - memstall_o=1 combinationally in this same cycle.
- MISS:
  - memstall_o=1.
  - Miss counter increments each cycle.
  - dmem_ack_i=1 -> RELEASE. memstall_o stays 1 in the ack cycle.
  - Counter reaching ACK_TIMEOUT with no ack -> ERR.
- RELEASE:
  - memstall_o=0 for exactly one cycle, regardless of dmem_hit_i.
  - Always -> RUN.
- ERR:
  - memstall_o=1 and err_o=1.
  - Left only by reset.
- Load-use hazard: luse = idex_memread_i & (idex_rt_i != 0) & (idex_rt_i == ifid_rs_i | idex_rt_i == ifid_rt_i).
- Priority, highest first:
  - memstall_o=1: pc_write_o=0, ifid_write_o=0, ifid_flush_o=0, idex_bubble_o=0 (everything holds).
  - luse=1: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, ifid_flush_o=0. A simultaneous branch_taken_i is ignored; the branch re-resolves next cycle.
  - branch_taken_i=1: ifid_flush_o=1; pc_write_o=1, ifid_write_o=1.
  - Otherwise: pc_write_o=1, ifid_write_o=1, flush=0, bubble=0.
- Counters saturate at all-ones and never wrap. Each increments once per qualifying cycle, using the final prioritized outputs.

## Timing
- All control outputs are combinational from inputs and registered state. There are no registered outputs except err_o and the counters.
- During reset (rst_i=0), outputs are forced:
  - pc_write_o=0, ifid_write_o=0, ifid_flush_o=1, idex_bubble_o=1.
  - memstall_o=0, err_o=0, all counters 0.
- Miss detected in cycle N, ack in cycle M (M>N): memstall_o=1 for cycles N..M, 0 at M+1 (RELEASE), back in RUN at M+2.
- dmem_ack_i outside MISS is ignored.
- Reset asserted mid-MISS: immediate return to RUN. The miss counter and err_o clear.

## Configuration
- Macro: HAZ_PERF_CNT_EN.
- Defined: stall_cnt_o, luse_cnt_o and flush_cnt_o count as specified.
- Undefined: the counter registers are not built. The ports remain and are tied to 0.

## Test plan
- Miss: req=1, hit=0 at cycle 10, ack at cycle 14 -> memstall_o=1 in cycles 10–14, 0 at 15, stall_cnt_o=5.
- Load-use: idex_memread=1, idex_rt=8, ifid_rs=8 -> pc_write=0, ifid_write=0, bubble=1. Same case with idex_rt=0 -> no stall.
- Simultaneous events:
  - Load-use plus branch_taken -> only the bubble, flush=0.
  - Miss plus load-use plus branch -> memstall=1 and all other controls 0.
- Timeout: ACK_TIMEOUT=8, miss with no ack -> err_o=1 after 8 MISS cycles, memstall_o stays 1. rst_i low clears both.
- Reset mid-miss: rst_i low in cycle 3 of MISS -> next ack is ignored, memstall_o=0 after release of reset.
- Counter saturation: CNT_W=4, 20 taken branches -> flush_cnt_o=15.
